// File: rtl/ledger_result_sink.sv
// ---------------------------------------------------------------------------
// ledger_result_sink
//
// Consumes the ledger core's result stream, which cannot be stalled. Every
// result that finds room is stored in a first-word fall-through record FIFO
// tagged with a sequence number. Results that find the FIFO full are dropped
// and counted. Saturating ok/fail/drop statistics are kept alongside.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid ...         result stream from the ledger core (no backpressure)
//   in_bal_payee
//   out_valid/out_ready  valid/ready record stream towards the host/logger
//   out_seq ...          head record fields; all zero while the FIFO is empty
//   out_bal_payee
//   stat_clear           synchronous clear of the stat_* counters
//   stat_ok/fail/drop    saturating result statistics
//   fifo_level           current FIFO occupancy (0..DEPTH)
// ---------------------------------------------------------------------------
module ledger_result_sink #(
   parameter int USER_WIDTH    = 10,
   parameter int BALANCE_WIDTH = 64,
   parameter int DEPTH         = 16,
   parameter int SEQ_WIDTH     = 32,
   parameter int STAT_WIDTH    = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic                       in_success,
   input  logic [USER_WIDTH-1:0]      in_payer,
   input  logic [USER_WIDTH-1:0]      in_payee,
   input  logic [BALANCE_WIDTH-1:0]   in_bal_payer,
   input  logic [BALANCE_WIDTH-1:0]   in_bal_payee,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [SEQ_WIDTH-1:0]       out_seq,
   output logic                       out_success,
   output logic [USER_WIDTH-1:0]      out_payer,
   output logic [USER_WIDTH-1:0]      out_payee,
   output logic [BALANCE_WIDTH-1:0]   out_bal_payer,
   output logic [BALANCE_WIDTH-1:0]   out_bal_payee,
   input  logic                       stat_clear,
   output logic [STAT_WIDTH-1:0]      stat_ok,
   output logic [STAT_WIDTH-1:0]      stat_fail,
   output logic [STAT_WIDTH-1:0]      stat_drop,
   output logic [$clog2(DEPTH):0]     fifo_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   localparam logic [LW-1:0]         LVL_ONE  = LW'(1);
   localparam logic [LW-1:0]         LVL_FULL = LW'(DEPTH);
   localparam logic [AW-1:0]         PTR_ONE  = AW'(1);
   localparam logic [SEQ_WIDTH-1:0]  SEQ_ONE  = SEQ_WIDTH'(1);
   localparam logic [STAT_WIDTH-1:0] STAT_ONE = STAT_WIDTH'(1);
   localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

   typedef struct packed {
      logic [SEQ_WIDTH-1:0]     seq;
      logic                     success;
      logic [USER_WIDTH-1:0]    payer;
      logic [USER_WIDTH-1:0]    payee;
      logic [BALANCE_WIDTH-1:0] bal_payer;
      logic [BALANCE_WIDTH-1:0] bal_payee;
   } rec_t;

   rec_t                 mem [DEPTH];
   rec_t                 head;
   rec_t                 wr_rec;
   logic [AW-1:0]        rd_ptr;
   logic [AW-1:0]        wr_ptr;
   logic [LW-1:0]        level;
   logic [SEQ_WIDTH-1:0] seq_cnt;
   logic                 full;
   logic                 push;
   logic                 pop;
   logic                 drop;

   assign full      = (level == LVL_FULL);
   assign out_valid = (level != '0);
   assign pop       = out_valid & out_ready;
   // A pop in the same cycle frees the slot the push needs, so a full FIFO
   // that is being drained still accepts the incoming result.
   assign push      = in_valid & (~full | pop);
   assign drop      = in_valid & ~push;

   assign wr_rec = '{seq:       seq_cnt,
                     success:   in_success,
                     payer:     in_payer,
                     payee:     in_payee,
                     bal_payer: in_bal_payer,
                     bal_payee: in_bal_payee};

   // NOTE: the record storage is deliberately not reset; only the pointers
   // and level are, and the output gating below hides stale contents.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_rec;
   end

   // Fall-through head: storage is read combinationally, and the fields are
   // forced to zero whenever there is no valid record.
   assign head          = mem[rd_ptr];
   assign out_seq       = out_valid ? head.seq       : '0;
   assign out_success   = out_valid ? head.success   : 1'b0;
   assign out_payer     = out_valid ? head.payer     : '0;
   assign out_payee     = out_valid ? head.payee     : '0;
   assign out_bal_payer = out_valid ? head.bal_payer : '0;
   assign out_bal_payee = out_valid ? head.bal_payee : '0;
   assign fifo_level    = level;

   // NOTE: all state below uses non-blocking assignments so every register
   // samples the pre-edge values of push/pop/level in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         level   <= '0;
         seq_cnt <= '0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !pop)      level <= level + LVL_ONE;
         else if (pop && !push) level <= level - LVL_ONE;
         // Dropped results still consume a number, so gaps reveal drops.
         if (in_valid) seq_cnt <= seq_cnt + SEQ_ONE;
      end
   end

   // Statistics: clear has priority over counting the same-cycle result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_ok   <= '0;
         stat_fail <= '0;
         stat_drop <= '0;
      end else if (stat_clear) begin
         stat_ok   <= '0;
         stat_fail <= '0;
         stat_drop <= '0;
      end else if (in_valid) begin
         if (in_success && stat_ok != STAT_MAX)    stat_ok   <= stat_ok + STAT_ONE;
         if (!in_success && stat_fail != STAT_MAX) stat_fail <= stat_fail + STAT_ONE;
         if (drop && stat_drop != STAT_MAX)        stat_drop <= stat_drop + STAT_ONE;
      end
   end

endmodule

// File: doc/ledger_result_sink.md
Name: ledger_result_sink

Overview:
- Downstream consumer of the ledger core's result port (m_valid/m_success/m_payer/m_payee/m_bal_payer/m_bal_payee).
- The ledger core has no backpressure. This block therefore captures every result it can into a record FIFO, tags each result with a sequence number, and keeps saturating statistics.
- It drains records to a host/logger through a valid/ready interface.
- Results that arrive while the FIFO cannot accept them are dropped and counted. The ledger core is never stalled.

Parameters:
- USER_WIDTH, 10, user index width; matches the ledger core.
- BALANCE_WIDTH, 64, balance width; matches the ledger core.
- DEPTH, 16, record FIFO entries; must be a power of two and at least 2.
- SEQ_WIDTH, 32, sequence-number width.
- STAT_WIDTH, 32, width of each statistics counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  result valid; connects to ledger core m_valid.
- in_success  in  1  transfer succeeded; connects to m_success.
- in_payer  in  USER_WIDTH  payer index.
- in_payee  in  USER_WIDTH  payee index.
- in_bal_payer  in  BALANCE_WIDTH  payer balance after the transaction.
- in_bal_payee  in  BALANCE_WIDTH  payee balance after the transaction.
- out_valid  out  1  record available.
- out_ready  in  1  consumer accepts the record.
- out_seq  out  SEQ_WIDTH  sequence number of the record.
- out_success  out  1  success flag of the record.
- out_payer  out  USER_WIDTH  payer index of the record.
- out_payee  out  USER_WIDTH  payee index of the record.
- out_bal_payer  out  BALANCE_WIDTH  payer balance of the record.
- out_bal_payee  out  BALANCE_WIDTH  payee balance of the record.
- stat_clear  in  1  synchronous clear of the stat_* counters.
- stat_ok  out  STAT_WIDTH  count of successful results seen.
- stat_fail  out  STAT_WIDTH  count of failed results seen.
- stat_drop  out  STAT_WIDTH  count of results dropped because the FIFO was full.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, rst_n low):
  - FIFO empty; read/write pointers at 0; fifo_level=0; out_valid=0.
  - Sequence counter=0; stat_ok=stat_fail=stat_drop=0.
  - All out_* data outputs read as 0 while the FIFO is empty.
- Reset mid-operation discards all stored records. Records in flight are not preserved.
- Sequence numbering:
  - Every cycle with in_valid=1 consumes one sequence number, whether the result is stored or dropped.
  - The record carries the pre-increment value.
  - The counter wraps modulo 2^SEQ_WIDTH.
  - stat_clear does not affect the counter, so a gap in out_seq identifies drops.
- Pop: pop = out_valid & out_ready.
- Push:
  - push = in_valid & (fifo_level<DEPTH | pop).
  - When the FIFO is full, a pop in the same cycle frees a slot, so the push succeeds.
  - When push is denied with in_valid=1, the result is dropped.
- Output timing:
  - The FIFO is first-word fall-through: out_valid = (fifo_level!=0), and out_* present the head entry combinationally from storage.
  - No input-to-output bypass: a record pushed at edge N is visible no earlier than after edge N (1-cycle latency).
  - out_* must stay stable while out_valid=1 and out_ready=0.
- Level update: fifo_level += push − pop each cycle. A simultaneous push and pop leaves the level unchanged. Pointers wrap modulo DEPTH.
- Statistics (evaluated for each in_valid=1 cycle):
  - in_success=1 increments stat_ok.
  - in_success=0 increments stat_fail.
  - If additionally dropped, stat_drop increments.
  - ok/fail are counted regardless of whether the result was dropped.
  - All counters saturate at 2^STAT_WIDTH−1 and do not wrap.
- stat_clear:
  - Zeroes stat_ok, stat_fail and stat_drop at the next edge.
  - If in_valid is high in the same cycle, clear wins: that result is not counted in the stats, but it is still pushed or dropped normally and still consumes a sequence number.
- Out-of-range or X input data while in_valid=0 is ignored.

Test Plan:
- Reset, then 3 consecutive in_valid pulses (success=1,1,0), out_ready=1:
  - out_seq=0,1,2 appear one cycle after each pulse.
  - stat_ok=2, stat_fail=1, stat_drop=0.
- out_ready=0, 20 back-to-back successful results, DEPTH=16:
  - fifo_level=16; stat_drop=4; stat_ok=20.
  - Drain then yields out_seq=0..15 in order with a stable head while stalled.
- FIFO full (level=16), out_ready=1 and in_valid=1 in the same cycle:
  - push accepted; level stays 16; stat_drop unchanged.
  - New record seq follows the previous one with no gap.
- stat_clear asserted in the same cycle as a failed result:
  - all stats = 0 next cycle.
  - The record is still stored, and its seq is the previous seq + 1.
- Force stat_ok to 2^32−1 (or use STAT_WIDTH=4 with 17 successes): counter holds at max and does not wrap.
- Assert rst_n low while level=5 and out_valid=1:
  - out_valid=0, level=0 and all stats = 0 immediately (asynchronously).
  - The next result after reset carries seq 0.
